// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shared widths, stage count and operation encodings for the shift pipeline
package shift_pipe_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int NUM_STAGES = 4;
  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;
endpackage

// File: rtl/shift_pipe_if.sv
// shift_pipe_if: request/result handshake bundle between a producer/consumer and the shift pipeline
interface shift_pipe_if import shift_pipe_pkg::*; #(
  parameter int WIDTH = shift_pipe_pkg::WIDTH,
  parameter int CNT_W = shift_pipe_pkg::CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic [CNT_W-1:0] in_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  modport master (
    output in_valid, in_data, in_op, in_cnt, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_op, in_cnt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_stage.sv
// shift_stage: one fixed-distance rotate/shift step, bypassed when en is low
module shift_stage import shift_pipe_pkg::*; #(
  parameter int WIDTH = shift_pipe_pkg::WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] y
);
  logic            right;
  logic            zero;
  logic [DIST-1:0] fill_l;
  logic [DIST-1:0] fill_r;
  always_comb begin
    right  = op == OP_ROR || op == OP_SRL;
    zero   = op == OP_SLL || op == OP_SRL;
    fill_l = zero ? '0 : data[WIDTH-1 -: DIST];
    fill_r = zero ? '0 : data[DIST-1:0];
    y      = !en ? data : right ? {fill_r, data[WIDTH-1:DIST]} : {data[WIDTH-1-DIST:0], fill_l};
  end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: four-stage elastic barrel shifter; stage k shifts by 2^k when cnt[k] is set
module shift_pipe import shift_pipe_pkg::*; #(
  parameter int WIDTH = shift_pipe_pkg::WIDTH,
  parameter int CNT_W = shift_pipe_pkg::CNT_W
) (
  input logic       clk,
  input logic       rst_n,
  shift_pipe_if.slave bus
);
  logic [NUM_STAGES-1:0] v_q;
  logic [NUM_STAGES-1:0] ld;
  logic [NUM_STAGES-1:0] src_v;
  logic [WIDTH-1:0]      d_q     [NUM_STAGES];
  logic [WIDTH-1:0]      src_d   [NUM_STAGES];
  logic [WIDTH-1:0]      sh      [NUM_STAGES];
  logic [1:0]            op_q    [NUM_STAGES];
  logic [1:0]            src_op  [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_q   [NUM_STAGES];
  logic [CNT_W-1:0]      src_cnt [NUM_STAGES];
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v[k]   = bus.in_valid;
      assign src_d[k]   = bus.in_data;
      assign src_op[k]  = bus.in_op;
      assign src_cnt[k] = bus.in_cnt;
    end else begin : g_body
      assign src_v[k]   = v_q[k-1];
      assign src_d[k]   = d_q[k-1];
      assign src_op[k]  = op_q[k-1];
      assign src_cnt[k] = cnt_q[k-1];
    end
    // a stage may load unless it and every stage downstream are full with the output stalled
    assign ld[k] = bus.out_ready || !(&v_q[NUM_STAGES-1:k]);
    shift_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
      .data (src_d[k]),
      .op   (src_op[k]),
      .en   (src_cnt[k][k]),
      .y    (sh[k])
    );
  end
  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_q[NUM_STAGES-1];
  assign bus.out_data  = d_q[NUM_STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v_q <= '0;
    else v_q <= (v_q & ~ld) | (src_v & ld);
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_STAGES; i++)
      if (ld[i]) begin
        d_q[i]   <= sh[i];
        op_q[i]  <= src_op[i];
        cnt_q[i] <= src_cnt[i];
      end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe with directed vectors, stalls, random traffic and reset
module tb_shift_pipe;
  import shift_pipe_pkg::*;
  typedef struct {
    logic [15:0] d;
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [15:0] exp;
  } vec_t;
  typedef struct {
    logic [15:0] exp;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cmps = 0;
  int errs = 0;
  int cyc = 0;
  bit lat_chk = 0;
  bit rnd_done = 0;
  bit stalled = 0;
  logic [15:0] held;
  exp_t mon_e;
  exp_t q[$];
  vec_t vecs [14] = '{
    '{16'h8001, OP_ROL, 4'd1,  16'h0003},
    '{16'h00FF, OP_SLL, 4'd8,  16'hFF00},
    '{16'h8000, OP_SRL, 4'd15, 16'h0001},
    '{16'h1234, OP_ROR, 4'd4,  16'h4123},
    '{16'hA5A5, OP_ROL, 4'd0,  16'hA5A5},
    '{16'hA5A5, OP_SLL, 4'd0,  16'hA5A5},
    '{16'hA5A5, OP_ROR, 4'd0,  16'hA5A5},
    '{16'hA5A5, OP_SRL, 4'd0,  16'hA5A5},
    '{16'h1234, OP_ROL, 4'd4,  16'h2341},
    '{16'h0001, OP_SLL, 4'd15, 16'h8000},
    '{16'h0001, OP_ROR, 4'd1,  16'h8000},
    '{16'hFFFF, OP_SRL, 4'd4,  16'h0FFF},
    '{16'hF00F, OP_ROL, 4'd12, 16'hFF00},
    '{16'h00F0, OP_ROR, 4'd7,  16'hE001}
  };
  shift_pipe_if bus ();
  shift_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [15:0] model(logic [15:0] d, logic [1:0] op, logic [3:0] c);
    return op == OP_ROL ? (d << c) | (d >> (16 - c)) :
           op == OP_SLL ? d << c :
           op == OP_ROR ? (d >> c) | (d << (16 - c)) : d >> c;
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic send(input vec_t v);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v.d;
    bus.in_op    = v.op;
    bus.in_cnt   = v.cnt;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        q.push_back('{exp: v.exp, cyc: cyc});
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accept", 16'(acc), 16'd1);
  endtask
  task automatic drain();
    for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("outstanding", 16'(q.size()), 16'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) begin
        cmps++;
        if (!bus.out_valid || bus.out_data !== held) begin
          errs++;
          $display("FAIL hold: out_valid=%b out_data=%h, expected out_valid=1 out_data=%h",
                   bus.out_valid, bus.out_data, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        cmps++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected: out_data=%h emerged with no request outstanding", bus.out_data);
        end else begin
          mon_e = q.pop_front();
          if (bus.out_data !== mon_e.exp) begin
            errs++;
            $display("FAIL data: got %h, expected %h", bus.out_data, mon_e.exp);
          end
          if (lat_chk) begin
            cmps++;
            if (cyc - mon_e.cyc != 4) begin
              errs++;
              $display("FAIL latency: got %0d cycles, expected 4", cyc - mon_e.cyc);
            end
          end
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_op = '0;
    bus.in_cnt = '0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 16'(bus.out_valid), 16'd0);
    chk("reset in_ready", 16'(bus.in_ready), 16'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post-reset in_ready", 16'(bus.in_ready), 16'd1);
    chk("post-reset out_valid", 16'(bus.out_valid), 16'd0);
    bus.out_ready = 1'b1;
    lat_chk = 1;
    foreach (vecs[i]) send(vecs[i]);
    drain();
    lat_chk = 0;
    bus.out_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(vecs[i]);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full in_ready", 16'(bus.in_ready), 16'd0);
        chk("full out_valid", 16'(bus.out_valid), 16'd1);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          vec_t v;
          v.d = 16'($urandom);
          v.op = 2'($urandom_range(0, 3));
          v.cnt = 4'($urandom_range(0, 15));
          v.exp = model(v.d, v.op, v.cnt);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(v);
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    join
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i]);
    @(posedge clk);
    #1;
    chk("in-flight out_valid", 16'(bus.out_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 16'(bus.out_valid), 16'd0);
    chk("async reset in_ready", 16'(bus.in_ready), 16'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("release in_ready", 16'(bus.in_ready), 16'd1);
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no stale out_valid", 16'(bus.out_valid), 16'd0);
    chk("idle in_ready", 16'(bus.in_ready), 16'd1);
    send(vecs[3]);
    send(vecs[13]);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; only 16 is supported.
REQ-002 Parameter CNT_W, default 4, shift-count width (log2 WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  pipe accepts request this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL; bit1 = direction (1 = right).
REQ-009 in_cnt  input  CNT_W  shift amount 0..15.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  WIDTH  shifted/rotated result.

Function
REQ-013 Four pipeline stages S0..S3; stage k holds valid, data, op, cnt and applies a shift of 2^k positions when cnt[k]=1, pass-through otherwise.
REQ-014 Stage k input comes from in_* (k=0) or stage k-1 register; stage k output registered.
REQ-015 Per-stage fill: ROL/ROR wrap vacated bits from opposite end; SLL/SRL fill zeros; no arithmetic shift.
REQ-016 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-017 Stage k loads when its register is empty or stage k+1 loads this cycle (S3 "next" = output transfer); bubbles collapse.
REQ-018 in_ready = !S0.valid || S0 loads; combinational, no dependence on in_valid.
REQ-019 out_valid = S3.valid; out_data = S3.data; out_data stable while out_valid && !out_ready.
REQ-020 Latency: accepted request appears on out_valid exactly 4 cycles later when never stalled.
REQ-021 Throughput: one result per cycle with out_ready held high.
REQ-022 Results leave in acceptance order; no drop, no duplication under any out_ready pattern.
REQ-023 Full pipe (4 valid) with out_ready=0: in_ready=0; simultaneous output and input transfer on full pipe is permitted in the same cycle.
REQ-024 cnt=0: out_data equals in_data for all ops.
REQ-025 Stage with valid=0 holds data unchanged (no toggling of empty stages required but permitted; value is don't-care).

Reset
REQ-026 rst_n low clears all stage valid bits asynchronously; out_valid=0 immediately, in_ready=1 while rst_n low and first cycle after.
REQ-027 Data/op/cnt registers need not reset; out_data is don't-care while out_valid=0.
REQ-028 Reset mid-operation discards all in-flight requests; none emerge after release.

Structure
REQ-029 Shared package holds WIDTH, CNT_W, NUM_STAGES=4 and op encodings OP_ROL, OP_SLL, OP_ROR, OP_SRL.
REQ-030 One sub-module shift_stage (combinational, parameter DIST) computes one stage's shift; instantiated four times with DIST 1,2,4,8.
REQ-031 Handshake/valid logic lives in shift_pipe only; no latches, no combinational path out_ready -> out_data.

Verification
REQ-032 ROL 0x8001 cnt 1, out_ready=1 -> out_valid 4 cycles later, out_data 0x0003.
REQ-033 SLL 0x00FF cnt 8 -> 0xFF00; SRL 0x8000 cnt 15 -> 0x0001; ROR 0x1234 cnt 4 -> 0x4123; any op cnt 0 on 0xA5A5 -> 0xA5A5.
REQ-034 Six back-to-back requests, out_ready=0 for cycles 2..7 -> in_ready drops after 4 accepted, all six emerge in order, values correct.
REQ-035 Random out_ready (50%) with 1000 random requests vs reference model -> zero mismatches, zero losses.
REQ-036 Assert rst_n=0 with 3 requests in flight -> out_valid=0 same cycle; after release no stale result appears, in_ready=1.
